ctrl_pipe: RTL and testbench

//  Pipelined successor to the decode-stage control unit. Decodes opcode into EX/M/WB bundles.

---
 rtl/ctrl_pkg.sv | 47 ++++
 rtl/ctrl_pipe_if.sv | 31 +++
 rtl/ctrl_decode.sv | 58 +++++
 rtl/ctrl_pipe.sv | 175 +++++++++++++++++
 tb/tb_ctrl_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipelined control unit.
//   - opcode encodings recognised by the decoder
//   - widths of the EX / M / WB control bundles
//   - bit positions of every control signal inside its bundle
//   - decoder result structure and a small bundle helper
package ctrl_pkg;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_R    = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPC_W-1:0] OP_ADDI = 6'b001000;

    localparam int EX_W = 4;
    localparam int M_W  = 3;
    localparam int WB_W = 2;

    // EX bundle: {RegDst, ALUOp[1:0], ALUSrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

    // M bundle: {Branch, MemRead, MemWrite}
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;

    // WB bundle: {RegWrite, MemtoReg}
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef struct packed {
        logic [EX_W-1:0] ex;
        logic [M_W-1:0]  m;
        logic [WB_W-1:0] wb;
        logic            illegal;
        logic            uses_rt;   // rt is read as a source operand
    } dec_t;

    function automatic logic is_load(input logic [M_W-1:0] m);
        return m[M_MEMREAD];
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: ID-stage request and pipeline control outputs of ctrl_pipe.
//   master (ID stage / driver): id_valid, opcode, id_rs, id_rt, hold, flush
//   slave  (ctrl_pipe)        : stall_if_id, ex_ctrl, ex_illegal, mem_ctrl, wb_ctrl
interface ctrl_pipe_if #(
    parameter int REG_AW = 5
);
    import ctrl_pkg::*;

    logic              id_valid;
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              hold;
    logic              flush;

    logic              stall_if_id;
    logic [EX_W-1:0]   ex_ctrl;
    logic              ex_illegal;
    logic [M_W-1:0]    mem_ctrl;
    logic [WB_W-1:0]   wb_ctrl;

    modport master (
        output id_valid, opcode, id_rs, id_rt, hold, flush,
        input  stall_if_id, ex_ctrl, ex_illegal, mem_ctrl, wb_ctrl
    );

    modport slave (
        input  id_valid, opcode, id_rs, id_rt, hold, flush,
        output stall_if_id, ex_ctrl, ex_illegal, mem_ctrl, wb_ctrl
    );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decoder.
//   opcode : ID-stage opcode
//   dec    : EX/M/WB bundles, illegal flag and uses_rt for the hazard check
//   EXT_OPS: 1 also accepts addi, 0 treats addi as illegal
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit EXT_OPS = 1'b1
) (
    input  logic [OPC_W-1:0] opcode,
    output dec_t             dec
);

    always_comb begin
        // NOTE: defaults come first so every field is written on every path;
        // a field left unassigned on some path would infer a latch.
        dec         = '0;
        dec.illegal = 1'b1;
        case (opcode)
            OP_R: begin
                dec.ex[EX_REGDST]   = 1'b1;
                dec.ex[EX_ALUOP_HI] = 1'b1;
                dec.wb[WB_REGWRITE] = 1'b1;
                dec.uses_rt         = 1'b1;
                dec.illegal         = 1'b0;
            end
            OP_LW: begin
                dec.ex[EX_ALUSRC]   = 1'b1;
                dec.m[M_MEMREAD]    = 1'b1;
                dec.wb[WB_REGWRITE] = 1'b1;
                dec.wb[WB_MEMTOREG] = 1'b1;
                dec.illegal         = 1'b0;
            end
            OP_SW: begin
                dec.ex[EX_ALUSRC]   = 1'b1;
                dec.m[M_MEMWRITE]   = 1'b1;
                dec.uses_rt         = 1'b1;
                dec.illegal         = 1'b0;
            end
            OP_BEQ: begin
                dec.ex[EX_ALUOP_LO] = 1'b1;
                dec.m[M_BRANCH]     = 1'b1;
                dec.uses_rt         = 1'b1;
                dec.illegal         = 1'b0;
            end
            OP_ADDI: begin
                // rt is the destination of addi, never a source
                if (EXT_OPS) begin
                    dec.ex[EX_ALUSRC]   = 1'b1;
                    dec.wb[WB_REGWRITE] = 1'b1;
                    dec.illegal         = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control unit sitting at the ID/EX boundary.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : ctrl_pipe_if.slave
//              in : id_valid, opcode, id_rs, id_rt, hold, flush
//              out: stall_if_id (combinational load-use stall),
//                   ex_ctrl / ex_illegal (ID/EX), mem_ctrl (MEM1), wb_ctrl (MEM/WB)
// Stage order: ID/EX -> MEM1 .. MEM<MEM_LAT> -> MEM/WB. hold freezes all of them;
// a bubble (flush, load-use stall or invalid ID slot) loads zeros into ID/EX only.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter bit EXT_OPS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_pipe_if.slave bus
);

    dec_t dec;

    ctrl_decode #(.EXT_OPS(EXT_OPS)) u_decode (
        .opcode (bus.opcode),
        .dec    (dec)
    );

    // Producer that must stall an ID consumer: a load with a non-$0
    // destination that matches rs, or rt when the consumer reads rt.
    function automatic logic load_use(
        input logic [M_W-1:0]    m,
        input logic [REG_AW-1:0] dst,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rt,
        input logic              uses_rt
    );
        return is_load(m) && (dst != '0) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

    // ---------------------------------------------------------------- ID/EX
    logic [EX_W-1:0]   idex_ex_q, idex_ex_d;
    logic [M_W-1:0]    idex_m_q, idex_m_d;
    logic [WB_W-1:0]   idex_wb_q, idex_wb_d;
    logic              idex_ill_q, idex_ill_d;
    logic [REG_AW-1:0] idex_rt_q, idex_rt_d;

    logic stall;
    logic bubble;

    // Hazard taps: slot 0 is ID/EX, slot k is MEMk (k = 1 .. MEM_LAT-1).
    // The last MEM stage is never a tap: its load data is already forwardable.
    logic [MEM_LAT-1:0][M_W-1:0]    chk_m;
    logic [MEM_LAT-1:0][REG_AW-1:0] chk_rt;
    logic [MEM_LAT-1:0]             hit;

    // WB chain: slot 0 is ID/EX, slot i+1 is the output of MEM stage i.
    logic [MEM_LAT:0][WB_W-1:0] wb_chain;

    assign chk_m[0]    = idex_m_q;
    assign chk_rt[0]   = idex_rt_q;
    assign wb_chain[0] = idex_wb_q;

    for (genvar k = 0; k < MEM_LAT; k++) begin : g_hit
        assign hit[k] = load_use(chk_m[k], chk_rt[k], bus.id_rs, bus.id_rt, dec.uses_rt);
    end

    // A flushed or empty ID slot never stalls, so flush+hazard yields one bubble.
    assign stall  = !rst && bus.id_valid && !bus.flush && (|hit);
    assign bubble = bus.flush || stall || !bus.id_valid;

    always_comb begin
        idex_ex_d  = '0;
        idex_m_d   = '0;
        idex_wb_d  = '0;
        idex_ill_d = 1'b0;
        idex_rt_d  = '0;
        if (!bubble) begin
            idex_ex_d  = dec.ex;
            idex_m_d   = dec.m;
            idex_wb_d  = dec.wb;
            idex_ill_d = dec.illegal;
            idex_rt_d  = bus.id_rt;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge value of its neighbours regardless of block order.
        if (rst) begin
            idex_ex_q  <= '0;
            idex_m_q   <= '0;
            idex_wb_q  <= '0;
            idex_ill_q <= 1'b0;
            idex_rt_q  <= '0;
        end else if (!bus.hold) begin
            idex_ex_q  <= idex_ex_d;
            idex_m_q   <= idex_m_d;
            idex_wb_q  <= idex_wb_d;
            idex_ill_q <= idex_ill_d;
            idex_rt_q  <= idex_rt_d;
        end
    end

    // ------------------------------------------------------------ MEM stages
    // Every stage carries wb. m and dst_rt are kept in the stages that feed a
    // hazard tap (all but the last); the first stage also drives mem_ctrl.
    for (genvar i = 0; i < MEM_LAT; i++) begin : g_mem
        logic [WB_W-1:0] wb_q;

        always_ff @(posedge clk) begin
            // NOTE: every pipeline stage is cleared on reset -- these are control
            // flops, not storage, and a surviving bundle would fire a write later.
            if (rst) begin
                wb_q <= '0;
            end else if (!bus.hold) begin
                wb_q <= wb_chain[i];
            end
        end
        assign wb_chain[i+1] = wb_q;

        if (i < MEM_LAT - 1) begin : g_tap
            logic [M_W-1:0]    m_q;
            logic [REG_AW-1:0] rt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    m_q  <= '0;
                    rt_q <= '0;
                end else if (!bus.hold) begin
                    m_q  <= chk_m[i];
                    rt_q <= chk_rt[i];
                end
            end
            assign chk_m[i+1]  = m_q;
            assign chk_rt[i+1] = rt_q;
        end
    end

    logic [M_W-1:0] mem1_m;

    if (MEM_LAT == 1) begin : g_m_single
        // Single MEM stage: it is not a tap, so its M bundle lives here.
        logic [M_W-1:0] m_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                m_q <= '0;
            end else if (!bus.hold) begin
                m_q <= idex_m_q;
            end
        end
        assign mem1_m = m_q;
    end else begin : g_m_multi
        assign mem1_m = chk_m[1];
    end

    // ---------------------------------------------------------------- MEM/WB
    logic [WB_W-1:0] memwb_wb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            memwb_wb_q <= '0;
        end else if (!bus.hold) begin
            memwb_wb_q <= wb_chain[MEM_LAT];
        end
    end

    // --------------------------------------------------------------- outputs
    assign bus.stall_if_id = stall;
    assign bus.ex_ctrl     = idex_ex_q;
    assign bus.ex_illegal  = idex_ill_q;
    assign bus.mem_ctrl    = mem1_m;
    assign bus.wb_ctrl     = memwb_wb_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: two ctrl_pipe instances driven with the same stimulus:
//   dut0: MEM_LAT=1, EXT_OPS=1     dut1: MEM_LAT=2, EXT_OPS=0
// The reference model keeps, per instance, the list of bundles issued into
// the pipe (newest first); outputs are read by instruction age.
module tb_ctrl_pipe;

    localparam int AW = 5;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_BAD  = 6'b100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.REG_AW(AW)) if0 ();
    ctrl_pipe_if #(.REG_AW(AW)) if1 ();

    ctrl_pipe #(.REG_AW(AW), .MEM_LAT(1), .EXT_OPS(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    ctrl_pipe #(.REG_AW(AW), .MEM_LAT(2), .EXT_OPS(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------ model
    typedef struct packed {
        logic [3:0] ex;
        logic [2:0] m;
        logic [1:0] wb;
        logic       ill;
        logic [4:0] rt;
    } ent_t;

    typedef struct packed {
        logic       st;
        logic [3:0] ex;
        logic       ill;
        logic [2:0] mem;
        logic [1:0] wb;
    } out_t;

    ent_t hist [2][8];     // [instance][age], age 0 = instruction now in EX
    bit   model_ok = 1'b0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic ent_t mdec(input logic [5:0] op, input bit ext, input logic [4:0] rt);
        ent_t e;
        e    = '0;
        e.rt = rt;
        case (op)
            T_R:    {e.ex, e.m, e.wb} = {4'b1100, 3'b000, 2'b10};
            T_LW:   {e.ex, e.m, e.wb} = {4'b0001, 3'b010, 2'b11};
            T_SW:   {e.ex, e.m, e.wb} = {4'b0001, 3'b001, 2'b00};
            T_BEQ:  {e.ex, e.m, e.wb} = {4'b0010, 3'b100, 2'b00};
            T_ADDI: if (ext) {e.ex, e.m, e.wb} = {4'b0001, 3'b000, 2'b10};
                    else e.ill = 1'b1;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic bit m_uses_rt(input logic [5:0] op);
        return (op == T_R) || (op == T_SW) || (op == T_BEQ);
    endfunction

    // A load issued fewer than MEM_LAT slots ago blocks a dependent ID instruction.
    function automatic bit m_stall(input int d);
        if (rst || !if0.id_valid || if0.flush) return 1'b0;
        for (int j = 0; j < lat_of(d); j++) begin
            if (hist[d][j].m[1] && hist[d][j].rt != 5'd0 &&
                (hist[d][j].rt == if0.id_rs ||
                 (m_uses_rt(if0.opcode) && hist[d][j].rt == if0.id_rt)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int k = 0; k < 8; k++) hist[d][k] <= '0;
            end else if (!if0.hold) begin
                hist[d][0] <= (if0.flush || !if0.id_valid || m_stall(d)) ? '0
                              : mdec(if0.opcode, (d == 0), if0.id_rt);
                for (int k = 1; k < 8; k++) hist[d][k] <= hist[d][k-1];
            end
        end
        if (rst) model_ok <= 1'b1;
    end

    function automatic out_t dut_out(input int d);
        out_t o;
        if (d == 0) o = {if0.stall_if_id, if0.ex_ctrl, if0.ex_illegal, if0.mem_ctrl, if0.wb_ctrl};
        else        o = {if1.stall_if_id, if1.ex_ctrl, if1.ex_illegal, if1.mem_ctrl, if1.wb_ctrl};
        return o;
    endfunction

    // Compare process: every cycle, both instances, all outputs.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int d = 0; d < 2; d++) begin
                out_t o;
                o = dut_out(d);
                check($sformatf("stall d%0d", d), 16'(o.st), 16'(m_stall(d)));
                check($sformatf("ex_ctrl d%0d", d), 16'(o.ex), 16'(hist[d][0].ex));
                check($sformatf("ex_illegal d%0d", d), 16'(o.ill), 16'(hist[d][0].ill));
                check($sformatf("mem_ctrl d%0d", d), 16'(o.mem), 16'(hist[d][1].m));
                check($sformatf("wb_ctrl d%0d", d), 16'(o.wb), 16'(hist[d][lat_of(d)+1].wb));
            end
        end
    end

    // --------------------------------------------------------- stimulus
    task automatic drive(input logic r, input logic v, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic h, input logic f);
        rst          = r;
        if0.id_valid = v;  if1.id_valid = v;
        if0.opcode   = op; if1.opcode   = op;
        if0.id_rs    = rs; if1.id_rs    = rs;
        if0.id_rt    = rt; if1.id_rt    = rt;
        if0.hold     = h;  if1.hold     = h;
        if0.flush    = f;  if1.flush    = f;
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
        #1;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain;
        idle();
        repeat (4) adv();
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 6))
            0:       return T_R;
            1, 6:    return T_LW;
            2:       return T_SW;
            3:       return T_BEQ;
            4:       return T_ADDI;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        out_t o;
        logic [5:0] seq_op [5];
        logic [3:0] seq_ex [5];
        logic       seq_ill[5];

        seq_op  = '{T_R, T_LW, T_SW, T_BEQ, T_BAD};
        seq_ex  = '{4'b1100, 4'b0001, 4'b0001, 4'b0010, 4'b0000};
        seq_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset held two clocks with lw presented: everything stays zero.
        drive(1'b1, 1'b1, T_LW, 5'd1, 5'd2, 1'b0, 1'b0);
        adv(); adv();
        neg();
        for (int d = 0; d < 2; d++) begin
            o = dut_out(d);
            check($sformatf("reset outputs d%0d", d), 16'(o), 16'h0);
        end

        // lw latency: EX +1, MEM +2, WB +3.
        drive(1'b0, 1'b1, T_LW, 5'd1, 5'd2, 1'b0, 1'b0);
        adv();
        idle();
        neg(); o = dut_out(0); check("lw ex_ctrl", 16'(o.ex), 16'b0001);
        adv();
        neg(); o = dut_out(0); check("lw mem_ctrl", 16'(o.mem), 16'b010);
        adv();
        neg(); o = dut_out(0); check("lw wb_ctrl", 16'(o.wb), 16'b11);
        drain();

        // Decode sequence, no register overlap.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, seq_op[i], 5'd1, 5'(i + 9), 1'b0, 1'b0);
            adv();
            neg(); o = dut_out(0);
            check($sformatf("decode ex_ctrl #%0d", i), 16'(o.ex), 16'(seq_ex[i]));
            check($sformatf("decode ex_illegal #%0d", i), 16'(o.ill), 16'(seq_ill[i]));
        end
        drain();

        // Load-use: lw rt=5 then R rs=5.
        drive(1'b0, 1'b1, T_LW, 5'd0, 5'd5, 1'b0, 1'b0);
        adv();
        drive(1'b0, 1'b1, T_R, 5'd5, 5'd6, 1'b0, 1'b0);
        neg();
        o = dut_out(0); check("lu stall d0 c1", 16'(o.st), 16'd1);
        o = dut_out(1); check("lu stall d1 c1", 16'(o.st), 16'd1);
        adv();
        neg();
        o = dut_out(0); check("lu stall d0 c2", 16'(o.st), 16'd0);
        check("lu bubble ex d0", 16'(o.ex), 16'b0000);
        o = dut_out(1); check("lu stall d1 c2", 16'(o.st), 16'd1);
        adv();
        neg();
        o = dut_out(0); check("lu R ex d0", 16'(o.ex), 16'b1100);
        o = dut_out(1); check("lu stall d1 c3", 16'(o.st), 16'd0);
        check("lu bubble ex d1", 16'(o.ex), 16'b0000);
        adv();
        neg();
        o = dut_out(1); check("lu R ex d1", 16'(o.ex), 16'b1100);
        drain();

        // $0 never stalls; addi does not read rt.
        drive(1'b0, 1'b1, T_LW, 5'd1, 5'd0, 1'b0, 1'b0);
        adv();
        drive(1'b0, 1'b1, T_R, 5'd0, 5'd0, 1'b0, 1'b0);
        neg(); o = dut_out(0); check("r0 no stall", 16'(o.st), 16'd0);
        drain();
        drive(1'b0, 1'b1, T_LW, 5'd1, 5'd7, 1'b0, 1'b0);
        adv();
        drive(1'b0, 1'b1, T_ADDI, 5'd3, 5'd7, 1'b0, 1'b0);
        neg();
        o = dut_out(0); check("addi no stall d0", 16'(o.st), 16'd0);
        o = dut_out(1); check("addi no stall d1", 16'(o.st), 16'd0);
        adv();
        neg();
        o = dut_out(0); check("addi ex d0", 16'(o.ex), 16'b0001);
        o = dut_out(1); check("addi illegal d1", 16'(o.ill), 16'd1);
        drain();

        // hold freezes every stage for 3 clocks.
        drive(1'b0, 1'b1, T_R, 5'd1, 5'd2, 1'b0, 1'b0);  adv();
        drive(1'b0, 1'b1, T_LW, 5'd1, 5'd8, 1'b0, 1'b0); adv();
        drive(1'b0, 1'b1, T_SW, 5'd3, 5'd4, 1'b0, 1'b0); adv();
        drive(1'b0, 1'b1, T_BEQ, 5'd1, 5'd2, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            neg(); o = dut_out(0);
            check($sformatf("hold ex c%0d", c), 16'(o.ex), 16'b0001);
            check($sformatf("hold mem c%0d", c), 16'(o.mem), 16'b010);
            check($sformatf("hold wb c%0d", c), 16'(o.wb), 16'b10);
            if (c < 3) adv();
        end
        drain();

        // flush coinciding with a load-use hazard: one bubble, no stall.
        drive(1'b0, 1'b1, T_LW, 5'd0, 5'd5, 1'b0, 1'b0);
        adv();
        drive(1'b0, 1'b1, T_R, 5'd5, 5'd6, 1'b0, 1'b1);
        neg(); o = dut_out(0); check("flush stall", 16'(o.st), 16'd0);
        adv();
        idle();
        neg(); o = dut_out(0);
        check("flush bubble ex", 16'(o.ex), 16'b0000);
        check("flush lw mem", 16'(o.mem), 16'b010);
        drain();

        // rst while lw sits in MEM: bundle discarded, RegWrite never reaches WB.
        drive(1'b0, 1'b1, T_LW, 5'd1, 5'd3, 1'b0, 1'b0);
        adv();
        idle();
        adv();
        drive(1'b1, 1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        neg(); o = dut_out(0); check("rst pre mem", 16'(o.mem), 16'b010);
        adv();
        neg(); o = dut_out(0);
        check("rst mem cleared", 16'(o.mem), 16'b000);
        check("rst wb cleared", 16'(o.wb), 16'b00);
        idle();
        for (int c = 0; c < 3; c++) begin
            adv();
            neg();
            for (int d = 0; d < 2; d++) begin
                o = dut_out(d);
                check($sformatf("rst no regwrite d%0d c%0d", d, c), 16'(o.wb[1]), 16'd0);
            end
        end

        // Randomized traffic; small register range to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, pick_op(),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10);
            adv();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
